// File: rtl/wb_commit_unit.sv
// Write-back commit stage: selects and extends the GPR write value, drives the register-file
// write port and queues one trace record per retired instruction for a valid/ready debug port.
module wb_commit_unit #(
   parameter int TRACE_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_Valid,
   input  logic [31:0] WB_PC,
   input  logic [1:0]  WB_WbSel,
   input  logic [4:0]  WB_Dst,
   input  logic        WB_RegsWr,
   input  logic        WB_Except,
   input  logic [31:0] WB_ALUOut,
   input  logic [31:0] WB_Hi,
   input  logic [31:0] WB_DMOut,
   input  logic [1:0]  WB_LoadSize,
   input  logic        WB_LoadSign,
   output logic        WB_Stall,
   output logic        RF_We,
   output logic [4:0]  RF_Waddr,
   output logic [31:0] RF_Wdata,
   output logic        Trace_Valid,
   input  logic        Trace_Ready,
   output logic [31:0] Trace_PC,
   output logic [3:0]  Trace_Wen,
   output logic [4:0]  Trace_Waddr,
   output logic [31:0] Trace_Wdata,
   output logic [31:0] Commit_Count
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(TRACE_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t          mem [TRACE_DEPTH];
   rec_t          head;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   commit_cnt;
   logic [31:0]   wdata;
   logic          full;
   logic          commit;
   logic          push;
   logic          pop;

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   load_extract = {{24{sgn & b[7]}}, b};
         2'b01:   load_extract = {{16{sgn & h[15]}}, h};
         default: load_extract = word;
      endcase
   endfunction

   always_comb begin
      wdata = WB_ALUOut;
      case (WB_WbSel)
         2'b01:   wdata = load_extract(WB_DMOut, WB_ALUOut[1:0], WB_LoadSize, WB_LoadSign);
         2'b10:   wdata = WB_PC + 32'd8;
         2'b11:   wdata = WB_Hi;
         default: wdata = WB_ALUOut;
      endcase
   end

   // A full FIFO only blocks when the consumer is not draining this cycle.
   assign full     = (count == FULL_CNT);
   assign WB_Stall = WB_Valid & ~WB_Except & full & ~Trace_Ready;
   assign commit   = WB_Valid & ~WB_Except & ~WB_Stall;
   assign push     = commit;
   assign pop      = Trace_Valid & Trace_Ready;

   assign RF_We    = commit & WB_RegsWr & (WB_Dst != 5'd0);
   assign RF_Waddr = WB_Dst;
   assign RF_Wdata = wdata;

   assign head         = mem[rd_ptr];
   assign Trace_Valid  = (count != '0);
   assign Trace_PC     = head.pc;
   assign Trace_Wen    = {4{head.wen}};
   assign Trace_Waddr  = head.waddr;
   assign Trace_Wdata  = head.wdata;
   assign Commit_Count = commit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         commit_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (commit) commit_cnt <= commit_cnt + 32'd1;
      end
   end

   // Record storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{pc: WB_PC, wen: RF_We, waddr: WB_Dst, wdata: wdata};
   end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed and randomized bench for wb_commit_unit against a queue-based reference model.
module tb_wb_commit_unit;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic        WB_Valid;
   logic [31:0] WB_PC;
   logic [1:0]  WB_WbSel;
   logic [4:0]  WB_Dst;
   logic        WB_RegsWr;
   logic        WB_Except;
   logic [31:0] WB_ALUOut;
   logic [31:0] WB_Hi;
   logic [31:0] WB_DMOut;
   logic [1:0]  WB_LoadSize;
   logic        WB_LoadSign;
   logic        WB_Stall;
   logic        RF_We;
   logic [4:0]  RF_Waddr;
   logic [31:0] RF_Wdata;
   logic        Trace_Valid;
   logic        Trace_Ready;
   logic [31:0] Trace_PC;
   logic [3:0]  Trace_Wen;
   logic [4:0]  Trace_Waddr;
   logic [31:0] Trace_Wdata;
   logic [31:0] Commit_Count;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t        q[$];
   logic [31:0] cnt;
   int          n_assert;
   int          n_fail;

   wb_commit_unit #(.TRACE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .WB_Valid(WB_Valid), .WB_PC(WB_PC), .WB_WbSel(WB_WbSel),
      .WB_Dst(WB_Dst), .WB_RegsWr(WB_RegsWr), .WB_Except(WB_Except), .WB_ALUOut(WB_ALUOut),
      .WB_Hi(WB_Hi), .WB_DMOut(WB_DMOut), .WB_LoadSize(WB_LoadSize), .WB_LoadSign(WB_LoadSign),
      .WB_Stall(WB_Stall), .RF_We(RF_We), .RF_Waddr(RF_Waddr), .RF_Wdata(RF_Wdata),
      .Trace_Valid(Trace_Valid), .Trace_Ready(Trace_Ready), .Trace_PC(Trace_PC),
      .Trace_Wen(Trace_Wen), .Trace_Waddr(Trace_Waddr), .Trace_Wdata(Trace_Wdata),
      .Commit_Count(Commit_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] dm, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sg);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (dm >> (8 * off)) & 32'hFF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (dm >> (16 * off[1])) & 32'hFFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = dm;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_wdata();
      case (WB_WbSel)
         2'b00:   return WB_ALUOut;
         2'b01:   return ref_load(WB_DMOut, WB_ALUOut[1:0], WB_LoadSize, WB_LoadSign);
         2'b10:   return WB_PC + 32'd8;
         default: return WB_Hi;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] sel,
                        input logic [4:0] dst, input logic rw, input logic exc,
                        input logic [31:0] alu, input logic [31:0] hi, input logic [31:0] dm,
                        input logic [1:0] sz, input logic sg);
      WB_Valid = v; WB_PC = pc; WB_WbSel = sel; WB_Dst = dst; WB_RegsWr = rw;
      WB_Except = exc; WB_ALUOut = alu; WB_Hi = hi; WB_DMOut = dm;
      WB_LoadSize = sz; WB_LoadSign = sg;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0);
   endtask

   task automatic drive_rand(input logic [31:0] pc);
      drive(1'b1, pc, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom),
            1'b0, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
   endtask

   // One clock: check combinational outputs and FIFO head, then advance the model.
   task automatic cycle();
      logic        stall_e;
      logic        commit_e;
      logic        we_e;
      logic [31:0] wd_e;
      rec_t        r;
      #1;
      stall_e  = WB_Valid && !WB_Except && (q.size() == DEPTH) && !Trace_Ready;
      commit_e = WB_Valid && !WB_Except && !stall_e;
      we_e     = commit_e && WB_RegsWr && (WB_Dst != 5'd0);
      wd_e     = ref_wdata();
      check("wb_stall", 32'(WB_Stall), 32'(stall_e));
      check("rf_we", 32'(RF_We), 32'(we_e));
      if (we_e) begin
         check("rf_waddr", 32'(RF_Waddr), 32'(WB_Dst));
         check("rf_wdata", RF_Wdata, wd_e);
      end
      check("trace_valid", 32'(Trace_Valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("trace_pc", Trace_PC, q[0].pc);
         check("trace_wen", 32'(Trace_Wen), 32'(q[0].wen));
         check("trace_waddr", 32'(Trace_Waddr), 32'(q[0].waddr));
         check("trace_wdata", Trace_Wdata, q[0].wdata);
      end
      check("commit_count", Commit_Count, cnt);
      @(posedge clk);
      if (q.size() != 0 && Trace_Ready) void'(q.pop_front());
      if (commit_e) begin
         r.pc = WB_PC; r.wen = we_e ? 4'hF : 4'h0; r.waddr = WB_Dst; r.wdata = wd_e;
         q.push_back(r);
         cnt = cnt + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      idle();
      Trace_Ready = 1'b1;
      for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) cycle();
      #1 check("drain_empty", 32'(Trace_Valid), 32'd0);
      @(negedge clk);
   endtask

   task automatic fill(input int n, input logic [31:0] base);
      Trace_Ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive_rand(base + 32'(4 * i));
         cycle();
      end
      idle();
   endtask

   initial begin
      logic [31:0] c0;
      int          k;
      n_assert = 0; n_fail = 0; cnt = 32'd0;
      rst = 1'b1;
      Trace_Ready = 1'b0;
      drive(1'b1, 32'h40, 2'b00, 5'd7, 1'b1, 1'b0, 32'h1, 32'h0, 32'h0, 2'b10, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_trace_valid", 32'(Trace_Valid), 32'd0);
      check("rst_commit_count", Commit_Count, 32'd0);
      check("rst_stall_empty", 32'(WB_Stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      cycle();

      // Signed byte load at offset 2
      drive(1'b1, 32'h1000, 2'b01, 5'd5, 1'b1, 1'b0, 32'h2002, 32'h0, 32'h0080_0000, 2'b00, 1'b1);
      #1;
      check("t1_rf_we", 32'(RF_We), 32'd1);
      check("t1_rf_waddr", 32'(RF_Waddr), 32'd5);
      check("t1_rf_wdata", RF_Wdata, 32'hFFFF_FF80);
      cycle();
      idle();
      #1;
      check("t1_trace_valid", 32'(Trace_Valid), 32'd1);
      check("t1_trace_wen", 32'(Trace_Wen), 32'hF);
      check("t1_trace_wdata", Trace_Wdata, 32'hFFFF_FF80);
      drain();

      // PC+8 wrap, then the same with Dst=0
      drive(1'b1, 32'hFFFF_FFFC, 2'b10, 5'd31, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0);
      #1 check("t2_wdata_wrap", RF_Wdata, 32'h0000_0004);
      cycle();
      drain();
      c0 = cnt;
      drive(1'b1, 32'hFFFF_FFFC, 2'b10, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0);
      #1 check("t2_dst0_rf_we", 32'(RF_We), 32'd0);
      cycle();
      idle();
      #1;
      check("t2_dst0_trace_wen", 32'(Trace_Wen), 32'h0);
      check("t2_dst0_count", Commit_Count, c0 + 32'd1);
      drain();

      // Fill, stall the ninth, release with Trace_Ready
      fill(DEPTH, 32'h200);
      drive(1'b1, 32'h220, 2'b00, 5'd9, 1'b1, 1'b0, 32'hABCD, 32'h0, 32'h0, 2'b10, 1'b0);
      #1;
      check("t3_stall", 32'(WB_Stall), 32'd1);
      check("t3_stall_rf_we", 32'(RF_We), 32'd0);
      cycle();
      Trace_Ready = 1'b1;
      #1;
      check("t3_release_stall", 32'(WB_Stall), 32'd0);
      check("t3_release_rf_we", 32'(RF_We), 32'd1);
      cycle();
      idle();
      #1 check("t3_head_pc", Trace_PC, 32'h204);
      drain();

      // Full FIFO with simultaneous push and pop keeps occupancy at DEPTH
      fill(DEPTH, 32'h300);
      Trace_Ready = 1'b1;
      drive(1'b1, 32'h320, 2'b11, 5'd4, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 2'b10, 1'b0);
      #1 check("t4_no_stall", 32'(WB_Stall), 32'd0);
      cycle();
      idle();
      k = 0;
      while (Trace_Valid && k < 3 * DEPTH) begin
         cycle();
         k++;
      end
      check("t4_occupancy", 32'(k), 32'(DEPTH));

      // Excepting instruction against a full FIFO
      fill(DEPTH, 32'h400);
      c0 = cnt;
      drive(1'b1, 32'h420, 2'b00, 5'd3, 1'b1, 1'b1, 32'h55, 32'h0, 32'h0, 2'b10, 1'b0);
      #1;
      check("t5_no_stall", 32'(WB_Stall), 32'd0);
      check("t5_rf_we", 32'(RF_We), 32'd0);
      cycle();
      idle();
      #1 check("t5_count_same", Commit_Count, c0);
      drain();

      // Asynchronous reset in the middle of a drain
      fill(5, 32'h500);
      Trace_Ready = 1'b1;
      cycle();
      drive(1'b1, 32'h600, 2'b00, 5'd2, 1'b1, 1'b0, 32'h1, 32'h0, 32'h0, 2'b10, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t6_trace_valid", 32'(Trace_Valid), 32'd0);
      check("t6_commit_count", Commit_Count, 32'd0);
      q.delete();
      cnt = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      idle();
      cycle();

      // Randomized traffic; sparse Trace_Ready early so the FIFO fills
      for (int i = 0; i < 400; i++) begin
         Trace_Ready = (i < 200) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
         if ($urandom_range(0, 4) == 0) idle();
         else begin
            drive_rand(32'h1_0000 + 32'(4 * i));
            WB_Except = ($urandom_range(0, 7) == 0);
         end
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
